// File: rtl/mem_device_responder_pkg.sv
// Shared encodings for the memory read path: responder FSM, controller FSM,
// and a width helper for array indexing.
package mem_device_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } resp_state_t;

  typedef enum logic [1:0] {
    CTRL_IDLE     = 2'd0,
    CTRL_REQ      = 2'd1,
    CTRL_WAIT_RDY = 2'd2,
    CTRL_RELEASE  = 2'd3
  } ctrl_state_t;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_device_responder_mem_array.sv
// Single-port storage: synchronous write, combinational read.
// A read and a write to the same word at one edge returns the old contents.
module mem_array #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Backdoor write; contents are intentionally never cleared by reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mem_device_responder.sv
// Memory-side responder: accepts a read, inserts WAIT_CYCLES wait states,
// then presents registered data with mem_ready until mem_cs is released.
module mem_device_responder
  import mem_device_responder_pkg::*;
#(
  parameter int size        = 16,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_cs,
  input  logic            mem_read,
  input  logic [size-1:0] mem_addr_bus,
  output logic            mem_ready,
  output logic [size-1:0] mem_data_bus,
  output logic            addr_err,
  input  logic            ld_en,
  input  logic [size-1:0] ld_addr,
  input  logic [size-1:0] ld_data
);

  localparam int              AW      = clog2(DEPTH);
  localparam int              IDX_W   = (AW < 1) ? 1 : AW;
  localparam logic [size:0]   DEPTH_L = (size + 1)'(DEPTH);
  localparam logic [3:0]      WAIT_L  = 4'(WAIT_CYCLES);

  resp_state_t     r_state;
  resp_state_t     w_next;
  logic [3:0]      r_cnt;
  logic [size-1:0] r_addr;

  logic            w_accept;
  logic            w_enter_ready;
  logic            w_release;
  logic [size-1:0] w_rd_addr;
  logic            w_rd_oor;
  logic [size-1:0] w_rd_data;
  logic            w_ld_we;

  assign w_accept = mem_cs & mem_read;

  // With zero wait states READY is entered from IDLE at the accepting edge,
  // before the address register is loaded, so read straight from the bus.
  assign w_rd_addr = (r_state == ST_IDLE) ? mem_addr_bus : r_addr;
  assign w_rd_oor  = ({1'b0, w_rd_addr} >= DEPTH_L);
  assign w_ld_we   = ld_en & ({1'b0, ld_addr} < DEPTH_L);

  mem_array #(
    .DATA_W (size),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem_array (
    .clk     (clk),
    .i_we    (w_ld_we),
    .i_waddr (ld_addr[IDX_W-1:0]),
    .i_wdata (ld_data),
    .i_raddr (w_rd_addr[IDX_W-1:0]),
    .o_rdata (w_rd_data)
  );

  // Next-state decode and READY entry/exit strobes.
  always_comb begin
    w_next        = r_state;
    w_enter_ready = 1'b0;
    w_release     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (WAIT_CYCLES == 0) begin
            w_next        = ST_READY;
            w_enter_ready = 1'b1;
          end else begin
            w_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!mem_cs) begin
          w_next = ST_IDLE;
        end else if (r_cnt == 4'd1) begin
          w_next        = ST_READY;
          w_enter_ready = 1'b1;
        end
      end
      ST_READY: begin
        if (!mem_cs) begin
          w_next    = ST_IDLE;
          w_release = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State register and wait-state counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && w_accept) begin
        r_cnt <= WAIT_L;
      end else if (r_state == ST_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  // Request address capture; only meaningful while a transaction is open.
  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE && w_accept) begin
      r_addr <= mem_addr_bus;
    end
  end

  // Response registers: loaded once at READY entry, held, cleared on release.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_ready    <= 1'b0;
      mem_data_bus <= '0;
      addr_err     <= 1'b0;
    end else if (w_enter_ready) begin
      mem_ready    <= 1'b1;
      mem_data_bus <= w_rd_oor ? '0 : w_rd_data;
      addr_err     <= w_rd_oor;
    end else if (w_release) begin
      mem_ready    <= 1'b0;
      mem_data_bus <= '0;
      addr_err     <= 1'b0;
    end
  end

endmodule

// File: doc/mem_device_responder.md
Name: mem_device_responder

Overview:
Memory-side responder for the controller-to-memory read interface (mem_cs, mem_read, mem_addr_bus, mem_ready, mem_data_bus). It accepts a read request and inserts a configurable number of wait states. It then returns the stored word with mem_ready and holds it until the initiator drops mem_cs. It serves as the synthesizable memory model behind the device controller in system builds and benches. A backdoor load port initializes contents.

Parameters:
size, 16, data and address bus width in bits.
DEPTH, 256, number of stored words; power of two, at most 2**size.
WAIT_CYCLES, 2, wait states between request acceptance and mem_ready; range 0..15.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  reset, synchronous, active-high.
mem_cs  input  1  request strobe from the controller.
mem_read  input  1  read qualifier; a request is valid only when mem_cs=1 and mem_read=1.
mem_addr_bus  input  size  word address, sampled at request acceptance.
mem_ready  output  1  response valid; registered.
mem_data_bus  output  size  read data; registered; zero when mem_ready=0.
addr_err  output  1  high together with mem_ready when the latched address is >= DEPTH.
ld_en  input  1  backdoor write enable.
ld_addr  input  size  backdoor word address; ignored when >= DEPTH.
ld_data  input  size  backdoor write data.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; mem_ready=0, mem_data_bus=0, addr_err=0; counter=0. Array contents are not cleared. Reset in any state aborts the transaction.
- States: IDLE, WAIT, READY.
- IDLE: when mem_cs=1 and mem_read=1 at an edge, latch the address and load counter=WAIT_CYCLES. Go to WAIT if WAIT_CYCLES>0; otherwise go to READY. mem_cs=1 with mem_read=0 is ignored: no response, stay IDLE.
- WAIT: counter decrements each edge. When counter==1 at an edge, go to READY. If mem_cs=0 at any edge in WAIT, abort to IDLE with no response.
- Entry to READY: at the transitioning edge, register mem_ready=1 and mem_data_bus=array[latched addr] (or 0 if out of range). Register addr_err accordingly. Latency: mem_ready is high WAIT_CYCLES+1 cycles after the accepting edge.
- READY: mem_ready, mem_data_bus and addr_err are held constant. When mem_cs=0 at an edge, return to IDLE and clear all three outputs at that edge. The handshake is four-phase: a new request is accepted no earlier than the edge after the return to IDLE. mem_addr_bus and mem_read changes during READY are ignored.
- Backdoor load: when ld_en=1 and ld_addr<DEPTH, array[ld_addr]=ld_data at the edge. Writes are allowed in any state, including during reset.
- Load/read collision: the array read happens at READY entry. A load to the same address at an earlier edge is visible. A load at the READY-entry edge itself returns old data (read-before-write). Data already held in READY is not updated by later loads.
- Address width: only the low log2(DEPTH) bits index the array. The range check uses the full size-bit value.

Decomposition:
- State encodings (IDLE=2'd0, WAIT=2'd1, READY=2'd2) go in a shared package with the other controller FSM encodings. The package also holds a clog2 helper for the index width.
- One natural sub-module: mem_array, a single-port synchronous-write, combinational-read storage of DEPTH x size. The FSM and counter stay in the top module.

Test Plan:
- Basic read, WAIT_CYCLES=2: load array[5]=16'hA5A5. Request addr 5 at edge t -> mem_ready=1, data=16'hA5A5 from edge t+3. Data held until mem_cs drops, then ready=0 and data=0 at that edge.
- Zero wait, WAIT_CYCLES=0: request addr 0 holding 16'h1234 -> ready at edge t+1. Back-to-back request one cycle after the release is accepted.
- Abort: drop mem_cs one cycle into WAIT -> mem_ready stays 0; the next request to addr 3 (16'h0003) completes normally.
- Out of range, DEPTH=256: request addr 16'h0100 -> mem_ready=1, addr_err=1, data=0. mem_cs=1 with mem_read=0 -> no response for 10 cycles.
- Collision: load array[7]=16'hBEEF during WAIT -> read returns 16'hBEEF. Load 16'hCAFE after READY entry -> held data stays 16'hBEEF.
- Reset mid-READY: assert rst for one cycle -> outputs 0 at that edge, state IDLE. A subsequent read of addr 5 still returns 16'hA5A5 because contents are retained.
